// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_pkg : shared constants, state type and field helper. Rev 1.0
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  localparam logic [5:0] FIELD_MAX = 6'd59;
  localparam logic       SEL_SEC   = 1'b1;
  localparam logic       SEL_MIN   = 1'b0;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_e;

  function automatic logic [5:0] field_inc(input logic [5:0] v);
    return (v >= FIELD_MAX) ? 6'd0 : v + 6'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_core_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_core_if : button/switch inputs and display bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface stopwatch_core_if;
  logic       adj_sw;
  logic       sel_sw;
  logic       pause_pulse;
  logic       clr_pulse;
  logic [5:0] min;
  logic [5:0] sec;
  logic       adjust;
  logic       selection;
  logic       paused;

  modport master (
    output adj_sw, sel_sw, pause_pulse, clr_pulse,
    input  min, sec, adjust, selection, paused
  );

  modport slave (
    input  adj_sw, sel_sw, pause_pulse, clr_pulse,
    output min, sec, adjust, selection, paused
  );
endinterface
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_divider : free-running 0..DIV-1 counter with one-cycle tick. Rev 1.0
// ---------------------------------------------------------------------------
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_clr,
  output logic tick
);
  localparam int         W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (sync_clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);
endmodule
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_core : MM:SS stopwatch with pause, clear and 2 Hz field adjust. Rev 1.0
// ---------------------------------------------------------------------------
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int DIV_1HZ = 100_000_000,
  parameter int DIV_2HZ = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_core_if.slave  sw
);
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       adjust_q, adjust_d;
  logic       selection_q, selection_d;
  logic       paused_q, paused_d;
  state_e     state_q, state_d;

  logic tick_1hz, tick_2hz;
  logic clr_1hz, clr_2hz;

  // Divider restarts are keyed to the edge on which registered adjust changes.
  assign clr_1hz = sw.clr_pulse | (adjust_q & ~sw.adj_sw);
  assign clr_2hz = ~adjust_q & sw.adj_sw;

  tick_divider #(.DIV(DIV_1HZ)) u_div_1hz (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (clr_1hz),
    .tick     (tick_1hz)
  );

  tick_divider #(.DIV(DIV_2HZ)) u_div_2hz (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (clr_2hz),
    .tick     (tick_2hz)
  );

  always_comb begin
    min_d       = min_q;
    sec_d       = sec_q;
    state_d     = state_q;
    adjust_d    = sw.adj_sw;
    selection_d = sw.sel_sw;

    if (!adjust_q && sw.pause_pulse && !sw.clr_pulse) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end

    if (sw.clr_pulse) begin
      min_d = 6'd0;
      sec_d = 6'd0;
    end else if (adjust_q) begin
      if (tick_2hz) begin
        if (selection_q == SEL_SEC) begin
          sec_d = field_inc(sec_q);
        end else begin
          min_d = field_inc(min_q);
        end
      end
    end else if (tick_1hz && ((state_q == RUN) || sw.pause_pulse)) begin
      // A tick landing on either pause transition still counts.
      sec_d = field_inc(sec_q);
      if (sec_q >= FIELD_MAX) begin
        min_d = field_inc(min_q);
      end
    end

    paused_d = (state_d == PAUSED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      adjust_q    <= 1'b0;
      selection_q <= 1'b0;
      paused_q    <= 1'b0;
      state_q     <= RUN;
    end else begin
      min_q       <= min_d;
      sec_q       <= sec_d;
      adjust_q    <= adjust_d;
      selection_q <= selection_d;
      paused_q    <= paused_d;
      state_q     <= state_d;
    end
  end

  assign sw.min       = min_q;
  assign sw.sec       = sec_q;
  assign sw.adjust    = adjust_q;
  assign sw.selection = selection_q;
  assign sw.paused    = paused_q;
endmodule
`default_nettype wire

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Time-keeping core that produces the min/sec/adjust/selection bundle consumed by the seven-segment display driver.
- Counts MM:SS from 00:00 to 59:59 at 1 Hz.
- Supports pause, clear, and an adjust mode in which the selected field increments at 2 Hz.
- Sits between the debounced button/switch conditioning and the display driver.
- All outputs are registered.

Parameters:
DIV_1HZ, 100_000_000, clk cycles per 1 Hz count tick (must be ≥2)
DIV_2HZ, 50_000_000, clk cycles per 2 Hz adjust tick (must be ≥2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
adj_sw  input  1  adjust-mode switch level (synchronised upstream)
sel_sw  input  1  adjust field select level: 1 = seconds, 0 = minutes
pause_pulse  input  1  single-cycle debounced pause/resume request
clr_pulse  input  1  single-cycle debounced clear request
min  output  6  minutes, binary 0..59
sec  output  6  seconds, binary 0..59
adjust  output  1  registered copy of adj_sw
selection  output  1  registered copy of sel_sw
paused  output  1  1 when counting is halted by pause

Behaviour:
Reset (rst_n=0, asynchronous):
- min=0, sec=0, adjust=0, selection=0, paused=0.
- Both divider counters = 0; state = RUN.

Divider (one instance per rate):
- Counter cnt runs 0..DIV-1 and wraps.
- tick is asserted for exactly one cycle when cnt==DIV-1.
- First 1 Hz tick occurs DIV_1HZ cycles after reset release.

Mode inputs:
- adjust and selection follow adj_sw and sel_sw with 1-cycle latency.
- All mode decisions use the registered adjust and selection, never the raw switches.

State machine, evaluated only when adjust=0:
- RUN: on pause_pulse → PAUSED.
- PAUSED: on pause_pulse → RUN.
- paused = (state==PAUSED).
- pause_pulse is ignored while adjust=1; state is retained across adjust entry and exit.

Counting (adjust=0, state=RUN, 1 Hz tick):
- sec<59: sec+1.
- sec==59: sec=0 and min+1.
- At 59:59: wraps to 00:00.
- min/sec update on the clock edge that samples tick, so the new value is visible the cycle after tick is high.

Adjust (adjust=1):
- The 1 Hz count is suspended; 1 Hz ticks are discarded and not queued.
- On each 2 Hz tick, the selected field increments: selection=1 → sec, selection=0 → min.
- 59 wraps to 0 with no carry into the other field; the non-selected field holds.
- Adjust increments occur regardless of the paused state.

Divider reset rules:
- clr_pulse zeroes the 1 Hz divider counter.
- A falling edge of registered adjust zeroes the 1 Hz divider, so the first post-adjust count arrives a full DIV_1HZ cycles later.
- The 2 Hz divider is zeroed on the rising edge of registered adjust, so the first adjust increment arrives DIV_2HZ cycles after entry.

Priority within a cycle:
- clr_pulse > pause_pulse > tick.
- clr_pulse sets min=sec=0 in any mode and does not change state.
- A pause_pulse coinciding with clr_pulse is ignored.
- A 1 Hz tick coinciding with a pause_pulse that enters PAUSED is still applied; a tick coinciding with a resume is also applied.

Width rules:
- min and sec never exceed 59.
- Comparisons are against the constant 59 at 6-bit width.
- Divider counters use $clog2(DIV) bits.

Decomposition:
- Package stopwatch_pkg holds:
  - FIELD_MAX = 6'd59
  - SEL_SEC = 1'b1, SEL_MIN = 1'b0
  - state enum {RUN, PAUSED}
- One sub-module, tick_divider:
  - parameter DIV; ports clk, rst_n, sync_clr, tick.
  - Instantiated twice, for 1 Hz and 2 Hz.
- All field, mode and state logic stays in stopwatch_core.

Test Plan:
All scenarios use DIV_1HZ=10, DIV_2HZ=4.
1. Release reset, run 600 cycles → tick count 60, reading 01:00; then preload via adjust to 59:59, one tick → 00:00.
2. pause_pulse at 03:07 → paused=1, value holds for 50 cycles; second pause_pulse → paused=0, next tick shows 03:08.
3. adj_sw=1, sel_sw=1 at 00:58 → adjust=1 one cycle later; after 4 cycles sec=59, after 8 cycles sec=0 with min unchanged.
4. adj_sw=1, sel_sw=0 at 59:10 → after 4 cycles min=0 and sec=10; pause_pulse during adjust leaves paused unchanged.
5. clr_pulse and pause_pulse in the same cycle, in RUN at 12:34 → 00:00, paused=0, next count exactly 10 cycles later.
6. Assert rst_n=0 asynchronously mid-adjust at 07:45 → all outputs 0 immediately, before the next clk edge.
